// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions for the generator and checker paths: state
// encoding, CRC width, default polynomial/seed and the good-frame residue.
package crc16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          CRC_W        = 16;
  localparam logic [15:0] DEFAULT_POLY = 16'h1021;
  localparam logic [15:0] DEFAULT_INIT = 16'hFFFF;

  // A frame carrying its own CRC (high byte first) leaves this value behind.
  localparam logic [15:0] CRC_RESIDUE  = 16'h0000;

endpackage

// File: rtl/crc16_byte_update.sv
// One-byte CRC-16 step, MSB first, non-reflected, combinational.
// Shared by the generator and the checker.
module crc16_byte_update
  import crc16_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = DEFAULT_POLY
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data,
  output logic [CRC_W-1:0] crc_out
);

  logic [CRC_W-1:0] w_crc;

  always_comb begin
    w_crc = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      w_crc = w_crc[CRC_W-1] ? ((w_crc << 1) ^ POLY) : (w_crc << 1);
    end
    crc_out = w_crc;
  end

endmodule

// File: rtl/crc16_frame_check.sv
// Receive-side CRC-16 frame checker: one byte per clock, one result per frame.
// Optional good/bad frame counters are enabled with CRC16_FRAME_CHECK_STATS_EN.
module crc16_frame_check
  import crc16_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY    = DEFAULT_POLY,
  parameter logic [CRC_W-1:0] INIT    = DEFAULT_INIT,
  parameter int               MAX_LEN = 1024,
  parameter int               LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst,
`ifdef CRC16_FRAME_CHECK_STATS_EN
  input  logic             stats_clr,
  output logic [15:0]      good_cnt,
  output logic [15:0]      bad_cnt,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             err_runt,
  output logic             err_long,
  output logic [LEN_W-1:0] frame_len,
  output logic [CRC_W-1:0] crc_calc
);

  localparam logic [LEN_W-1:0] MAX_CNT  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RUNT_LIM = LEN_W'(3);

  state_t           r_state;
  logic [CRC_W-1:0] r_crc;
  logic [LEN_W-1:0] r_count;
  logic             r_long;
  logic             r_in_ready;
  logic             r_frame_done;
  logic             r_crc_ok;
  logic             r_crc_err;
  logic             r_err_runt;
  logic             r_err_long;
  logic [LEN_W-1:0] r_frame_len;
  logic [CRC_W-1:0] r_crc_calc;

  logic             w_xfer;
  logic [CRC_W-1:0] w_crc_base;
  logic [CRC_W-1:0] w_crc_next;
  logic [LEN_W-1:0] w_count_next;

  assign w_xfer       = in_valid & r_in_ready;
  assign w_crc_base   = (r_state == IDLE) ? INIT : r_crc;
  assign w_count_next = (r_state == IDLE) ? LEN_W'(1) : (r_count + LEN_W'(1));

  crc16_byte_update #(.POLY(POLY)) u_byte_update (
    .crc_in  (w_crc_base),
    .data    (in_data),
    .crc_out (w_crc_next)
  );

  // Results are registered on the in_last transfer so they appear in the DONE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_crc        <= INIT;
      r_count      <= '0;
      r_long       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_frame_done <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_crc_err    <= 1'b0;
      r_err_runt   <= 1'b0;
      r_err_long   <= 1'b0;
      r_frame_len  <= '0;
      r_crc_calc   <= '0;
    end else begin
      case (r_state)
        IDLE, RUN: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_crc   <= w_crc_next;
            r_count <= w_count_next;
            if (in_last) begin
              r_state      <= DONE;
              r_in_ready   <= 1'b0;
              r_frame_done <= 1'b1;
              r_frame_len  <= w_count_next;
              r_crc_calc   <= w_crc_next;
              r_err_long   <= 1'b0;
              if (w_count_next < RUNT_LIM) begin
                r_crc_ok   <= 1'b0;
                r_crc_err  <= 1'b1;
                r_err_runt <= 1'b1;
              end else begin
                r_crc_ok   <= (w_crc_next == CRC_RESIDUE);
                r_crc_err  <= (w_crc_next != CRC_RESIDUE);
                r_err_runt <= 1'b0;
              end
            end else if (w_count_next == MAX_CNT) begin
              r_state <= DROP;
              r_long  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        // Overlong tail: keep draining bytes, CRC and count stay frozen.
        DROP: begin
          if (w_xfer && in_last) begin
            r_state      <= DONE;
            r_in_ready   <= 1'b0;
            r_frame_done <= 1'b1;
            r_frame_len  <= r_count;
            r_crc_calc   <= r_crc;
            r_crc_ok     <= 1'b0;
            r_crc_err    <= 1'b1;
            r_err_runt   <= 1'b0;
            r_err_long   <= r_long;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_in_ready   <= 1'b1;
          r_frame_done <= 1'b0;
          r_crc_ok     <= 1'b0;
          r_crc_err    <= 1'b0;
          r_crc        <= INIT;
          r_count      <= '0;
          r_long       <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign frame_done = r_frame_done;
  assign crc_ok     = r_crc_ok;
  assign crc_err    = r_crc_err;
  assign err_runt   = r_err_runt;
  assign err_long   = r_err_long;
  assign frame_len  = r_frame_len;
  assign crc_calc   = r_crc_calc;

`ifdef CRC16_FRAME_CHECK_STATS_EN
  logic [15:0] r_good_cnt;
  logic [15:0] r_bad_cnt;

  // Saturating frame counters; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else if (stats_clr) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else if (r_frame_done) begin
      if (r_crc_ok && (r_good_cnt != 16'hFFFF)) begin
        r_good_cnt <= r_good_cnt + 16'd1;
      end
      if (r_crc_err && (r_bad_cnt != 16'hFFFF)) begin
        r_bad_cnt <= r_bad_cnt + 16'd1;
      end
    end
  end

  assign good_cnt = r_good_cnt;
  assign bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_crc16_frame_check.sv
// Directed self-checking bench for crc16_frame_check (MAX_LEN=16 build).
// Also exercises the frame counters when CRC16_FRAME_CHECK_STATS_EN is defined.
module tb_crc16_frame_check;

  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 11;
  localparam int WAIT_LIMIT = 50;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             frame_done;
  logic             crc_ok;
  logic             crc_err;
  logic             err_runt;
  logic             err_long;
  logic [LEN_W-1:0] frame_len;
  logic [15:0]      crc_calc;
`ifdef CRC16_FRAME_CHECK_STATS_EN
  logic             stats_clr;
  logic [15:0]      good_cnt;
  logic [15:0]      bad_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int firstWait = 0;
  int restWait = 0;
  int doneBase = 0;
  logic [7:0] frameBuf [0:31];

  crc16_frame_check #(
    .POLY    (16'h1021),
    .INIT    (16'hFFFF),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef CRC16_FRAME_CHECK_STATS_EN
    .stats_clr  (stats_clr),
    .good_cnt   (good_cnt),
    .bad_cnt    (bad_cnt),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .frame_done (frame_done),
    .crc_ok     (crc_ok),
    .crc_err    (crc_err),
    .err_runt   (err_runt),
    .err_long   (err_long),
    .frame_len  (frame_len),
    .crc_calc   (crc_calc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done === 1'b1) doneCount++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offers one byte and returns just after the rising edge that accepted it.
  task automatic applyStimulus(input logic [7:0] d, input logic last, output int waited);
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= WAIT_LIMIT) checkOutput("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input int len, input bit gaps, input int breakAfter);
    int w;
    restWait = 0;
    for (int i = 0; i < len; i++) begin
      applyStimulus(frameBuf[i], (i == len - 1) && (breakAfter == 0), w);
      if (i == 0) firstWait = w;
      else restWait += w;
      if (breakAfter != 0 && i == breakAfter - 1) return;
      if (gaps && i != len - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic loadGood();
    logic [7:0] good [0:10];
    good = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h29, 8'hB1};
    for (int i = 0; i < 11; i++) frameBuf[i] = good[i];
  endtask

  task automatic checkGoodResult(input string tag);
    checkOutput({tag, "_done"},  32'(frame_done), 32'd1);
    checkOutput({tag, "_ok"},    32'(crc_ok),     32'd1);
    checkOutput({tag, "_err"},   32'(crc_err),    32'd0);
    checkOutput({tag, "_len"},   32'(frame_len),  32'd11);
    checkOutput({tag, "_calc"},  32'(crc_calc),   32'h0000);
    checkOutput({tag, "_runt"},  32'(err_runt),   32'd0);
    checkOutput({tag, "_long"},  32'(err_long),   32'd0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
`ifdef CRC16_FRAME_CHECK_STATS_EN
    stats_clr = 1'b0;
`endif
    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(in_ready),   32'd0);
    checkOutput("rst_done",  32'(frame_done), 32'd0);
    checkOutput("rst_ok",    32'(crc_ok),     32'd0);
    checkOutput("rst_err",   32'(crc_err),    32'd0);
    checkOutput("rst_runt",  32'(err_runt),   32'd0);
    checkOutput("rst_long",  32'(err_long),   32'd0);
    checkOutput("rst_len",   32'(frame_len),  32'd0);
    checkOutput("rst_calc",  32'(crc_calc),   32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_ready", 32'(in_ready), 32'd1);

    $display("[TB] good frame, continuous valid");
    loadGood();
    sendFrame(11, 1'b0, 0);
    checkGoodResult("good");
    checkOutput("good_done_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("good_pulse_end", 32'(frame_done), 32'd0);
    checkOutput("good_ok_clear",  32'(crc_ok),     32'd0);
    checkOutput("good_len_hold",  32'(frame_len),  32'd11);
    checkOutput("good_ready_back", 32'(in_ready),  32'd1);

    $display("[TB] corrupted frame");
    loadGood();
    frameBuf[4] = 8'h34;
    sendFrame(11, 1'b0, 0);
    checkOutput("bad_done",  32'(frame_done), 32'd1);
    checkOutput("bad_ok",    32'(crc_ok),     32'd0);
    checkOutput("bad_err",   32'(crc_err),    32'd1);
    checkOutput("bad_runt",  32'(err_runt),   32'd0);
    checkOutput("bad_long",  32'(err_long),   32'd0);
    checkOutput("bad_len",   32'(frame_len),  32'd11);
    checkOutput("bad_calc_nonzero", 32'(crc_calc != 16'h0000), 32'd1);

    $display("[TB] runt frame");
    frameBuf[0] = 8'hAA;
    frameBuf[1] = 8'h55;
    sendFrame(2, 1'b0, 0);
    checkOutput("runt_done", 32'(frame_done), 32'd1);
    checkOutput("runt_ok",   32'(crc_ok),     32'd0);
    checkOutput("runt_err",  32'(crc_err),    32'd1);
    checkOutput("runt_flag", 32'(err_runt),   32'd1);
    checkOutput("runt_long", 32'(err_long),   32'd0);
    checkOutput("runt_len",  32'(frame_len),  32'd2);

    $display("[TB] overlong frame");
    for (int i = 0; i < 20; i++) frameBuf[i] = 8'(i + 8'h40);
    sendFrame(20, 1'b0, 0);
    checkOutput("long_ready_drop", 32'(restWait),   32'd0);
    checkOutput("long_done",       32'(frame_done), 32'd1);
    checkOutput("long_ready_done", 32'(in_ready),   32'd0);
    checkOutput("long_ok",         32'(crc_ok),     32'd0);
    checkOutput("long_err",        32'(crc_err),    32'd1);
    checkOutput("long_flag",       32'(err_long),   32'd1);
    checkOutput("long_runt",       32'(err_runt),   32'd0);
    checkOutput("long_len",        32'(frame_len),  32'd16);
    @(posedge clk);
    #1;
    checkOutput("long_flag_hold",  32'(err_long),   32'd1);
    checkOutput("long_err_clear",  32'(crc_err),    32'd0);

    $display("[TB] gapped frame then back-to-back frame");
    doneBase = doneCount;
    loadGood();
    sendFrame(11, 1'b1, 0);
    checkGoodResult("gap");
    sendFrame(11, 1'b0, 0);
    checkOutput("b2b_ready_gap", 32'(firstWait), 32'd1);
    checkGoodResult("b2b");
    @(posedge clk);
    #1;
    checkOutput("b2b_pulses", 32'(doneCount - doneBase), 32'd2);

    $display("[TB] reset mid-frame");
    sendFrame(11, 1'b0, 4);
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    doneBase = doneCount;
    sendFrame(11, 1'b0, 0);
    checkGoodResult("after_rst");
    @(posedge clk);
    #1;
    checkOutput("after_rst_pulses", 32'(doneCount - doneBase), 32'd1);
`ifdef CRC16_FRAME_CHECK_STATS_EN
    checkOutput("stats_good", 32'(good_cnt), 32'd1);
    checkOutput("stats_bad",  32'(bad_cnt),  32'd0);
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    checkOutput("stats_clr_good", 32'(good_cnt), 32'd0);
    checkOutput("stats_clr_bad",  32'(bad_cnt),  32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
